rat_ckpt: RTL and testbench

Parametrised register alias table with branch checkpoints. It maps each architectural register to the ROB tag of its youngest in-flight producer. It serves RD_PORTS combinational source lookups, and keeps up to CKPT_NUM map snapshots in allocation order, so a mispredicted branch restores the map in one cycle instead of flushing it. It sits between decode/rename and the issue queue, fed by ROB allocate/commit and by branch resolution.

---
 rtl/rat_ckpt.sv | 167 ++++++++++++++++
 tb/tb_rat_ckpt.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rat_ckpt.sv
// rat_ckpt: register alias table with branch checkpoints.
// Maps each architectural register to the ROB tag of its youngest in-flight
// producer. Up to CKPT_NUM snapshots of the map are kept in allocation order
// so a mispredicted branch restores the map in a single cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rd_addr/rd_valid/rd_tag    RD_PORTS combinational source lookups
//   alloc_en/alloc_wen/alloc_dst/alloc_tag   rename one instruction
//   ckpt_req/ckpt_ready/ckpt_id              take a snapshot in slot ckpt_id
//   ckpt_release               free the oldest snapshot slot
//   recover_en/recover_id      restore the live map from a snapshot
//   commit_en/commit_dst/commit_tag          retire a register writer
//   flush_en                   clear all mappings and snapshots
//   ckpt_count                 number of live snapshots
module rat_ckpt #(
  parameter int ROB_DEPTH = 16,
  parameter int ARCH_REGS = 32,
  parameter int RD_PORTS  = 3,
  parameter int CKPT_NUM  = 4,
  localparam int TAG_W = $clog2(ROB_DEPTH),
  localparam int AW    = $clog2(ARCH_REGS),
  localparam int CW    = $clog2(CKPT_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RD_PORTS*AW-1:0]    rd_addr,
  output logic [RD_PORTS-1:0]       rd_valid,
  output logic [RD_PORTS*TAG_W-1:0] rd_tag,
  input  logic                      alloc_en,
  input  logic                      alloc_wen,
  input  logic [AW-1:0]             alloc_dst,
  input  logic [TAG_W-1:0]          alloc_tag,
  input  logic                      ckpt_req,
  output logic                      ckpt_ready,
  output logic [CW-1:0]             ckpt_id,
  input  logic                      ckpt_release,
  input  logic                      recover_en,
  input  logic [CW-1:0]             recover_id,
  input  logic                      commit_en,
  input  logic [AW-1:0]             commit_dst,
  input  logic [TAG_W-1:0]          commit_tag,
  input  logic                      flush_en,
  output logic [CW:0]               ckpt_count
);

  localparam logic [CW:0] FULL = (CW+1)'(CKPT_NUM);

  // Live map
  logic [ARCH_REGS-1:0] valid_reg, valid_next;
  logic [TAG_W-1:0]     tag_reg  [ARCH_REGS];
  logic [TAG_W-1:0]     tag_next [ARCH_REGS];

  // Read-only views of the snapshot slots, used by the recovery mux
  logic [ARCH_REGS-1:0] slot_valid [CKPT_NUM];
  logic [TAG_W-1:0]     slot_tag   [CKPT_NUM][ARCH_REGS];

  // Circular slot pointers
  logic [CW-1:0] head_reg, tail_reg;
  logic [CW:0]   count_reg;

  logic          do_recover, ckpt_take, ckpt_free;
  logic [CW-1:0] rec_off;

  assign do_recover = recover_en && !flush_en;
  assign ckpt_take  = ckpt_req && (count_reg != FULL) && !recover_en && !flush_en;
  assign ckpt_free  = ckpt_release && (count_reg != '0) && !recover_en && !flush_en;
  assign rec_off    = recover_id - head_reg;

  assign ckpt_ready = (count_reg != FULL);
  assign ckpt_id    = tail_reg;
  assign ckpt_count = count_reg;

  // Combinational lookups; x0 always reads as unmapped.
  genvar gi;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rd_addr[gi*AW +: AW];
      assign rd_valid[gi] = (addr != '0) && valid_reg[addr];
      assign rd_tag[gi*TAG_W +: TAG_W] = (addr != '0) ? tag_reg[addr] : '0;
    end
  endgenerate

  // Next live map. Recovery replaces the base map and drops the allocate;
  // the commit clear is applied after the base is chosen, and a same-cycle
  // allocate to the committing register overrides the clear.
  always_comb begin
    valid_next = valid_reg;
    tag_next   = tag_reg;
    if (do_recover) begin
      valid_next = slot_valid[recover_id];
      tag_next   = slot_tag[recover_id];
    end
    if (commit_en && valid_next[commit_dst] && (tag_next[commit_dst] == commit_tag))
      valid_next[commit_dst] = 1'b0;
    if (!do_recover && alloc_en && alloc_wen && (alloc_dst != '0)) begin
      valid_next[alloc_dst] = 1'b1;
      tag_next[alloc_dst]   = alloc_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int i = 0; i < ARCH_REGS; i++) tag_reg[i] <= '0;
    end else if (flush_en) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      tag_reg   <= tag_next;
    end
  end

  // Snapshot slots. A new snapshot captures the next-state map, so it already
  // includes this cycle's allocate and commit. Live slots are scrubbed by
  // every commit so a restored map never names a retired tag.
  generate
    for (gi = 0; gi < CKPT_NUM; gi++) begin : g_slot
      logic [ARCH_REGS-1:0] sv_reg;
      logic [TAG_W-1:0]     st_reg [ARCH_REGS];

      assign slot_valid[gi] = sv_reg;
      assign slot_tag[gi]   = st_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sv_reg <= '0;
          for (int i = 0; i < ARCH_REGS; i++) st_reg[i] <= '0;
        end else if (flush_en) begin
          sv_reg <= '0;
        end else if (ckpt_take && (tail_reg == CW'(gi))) begin
          sv_reg <= valid_next;
          st_reg <= tag_next;
        end else if (commit_en && sv_reg[commit_dst] && (st_reg[commit_dst] == commit_tag)) begin
          sv_reg[commit_dst] <= 1'b0;
        end
      end
    end
  endgenerate

  // Slot pointers. Recovery keeps the branch's own slot live and discards
  // every younger one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush_en) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (do_recover) begin
      tail_reg  <= recover_id + CW'(1);
      count_reg <= {1'b0, rec_off} + (CW+1)'(1);
    end else begin
      head_reg  <= head_reg + CW'(ckpt_free);
      tail_reg  <= tail_reg + CW'(ckpt_take);
      count_reg <= count_reg + (CW+1)'(ckpt_take) - (CW+1)'(ckpt_free);
    end
  end

  // Recovery must name a live slot: offset from head below the live count.
  recover_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    (recover_en && !flush_en) |-> ({1'b0, rec_off} < count_reg));

endmodule

// File: tb/tb_rat_ckpt.sv
module tb_rat_ckpt;
  localparam int ROB_DEPTH = 16;
  localparam int ARCH_REGS = 32;
  localparam int RD_PORTS  = 3;
  localparam int CKPT_NUM  = 4;
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int AW    = $clog2(ARCH_REGS);
  localparam int CW    = $clog2(CKPT_NUM);

  localparam int K_VALID = 0, K_TAG = 1, K_COUNT = 2, K_READY = 3, K_ID = 4;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [RD_PORTS*AW-1:0]    rd_addr;
  logic [RD_PORTS-1:0]       rd_valid;
  logic [RD_PORTS*TAG_W-1:0] rd_tag;
  logic                      alloc_en, alloc_wen;
  logic [AW-1:0]             alloc_dst;
  logic [TAG_W-1:0]          alloc_tag;
  logic                      ckpt_req, ckpt_ready;
  logic [CW-1:0]             ckpt_id;
  logic                      ckpt_release;
  logic                      recover_en;
  logic [CW-1:0]             recover_id;
  logic                      commit_en;
  logic [AW-1:0]             commit_dst;
  logic [TAG_W-1:0]          commit_tag;
  logic                      flush_en;
  logic [CW:0]               ckpt_count;

  rat_ckpt #(.ROB_DEPTH(ROB_DEPTH), .ARCH_REGS(ARCH_REGS), .RD_PORTS(RD_PORTS),
             .CKPT_NUM(CKPT_NUM)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_tag(rd_tag),
    .alloc_en(alloc_en), .alloc_wen(alloc_wen), .alloc_dst(alloc_dst), .alloc_tag(alloc_tag),
    .ckpt_req(ckpt_req), .ckpt_ready(ckpt_ready), .ckpt_id(ckpt_id),
    .ckpt_release(ckpt_release), .recover_en(recover_en), .recover_id(recover_id),
    .commit_en(commit_en), .commit_dst(commit_dst), .commit_tag(commit_tag),
    .flush_en(flush_en), .ckpt_count(ckpt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    kind;
    int    addr;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   port_rr = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic push(input string name, input int kind, input int addr, input int exp);
    exp_t it;
    it.name = name; it.kind = kind; it.addr = addr; it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic exp_map(input string name, input int addr, input int v, input int t);
    push({name, ".valid"}, K_VALID, addr, v);
    if (v != 0) push({name, ".tag"}, K_TAG, addr, t);
  endtask

  task automatic exp_ptr(input string name, input int cnt, input int id);
    push({name, ".count"}, K_COUNT, 0, cnt);
    push({name, ".ready"}, K_READY, 0, (cnt != CKPT_NUM) ? 1 : 0);
    push({name, ".id"}, K_ID, 0, id);
  endtask

  // Pop every pending expectation and compare against the DUT, rotating
  // lookups over the read ports.
  task automatic drain();
    exp_t it;
    int   p;
    int   got;
    logic [AW-1:0] a;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      p = port_rr % RD_PORTS;
      port_rr++;
      a = it.addr[AW-1:0];
      rd_addr = '0;
      rd_addr[p*AW +: AW] = a;
      #1;
      case (it.kind)
        K_VALID: got = int'(rd_valid[p]);
        K_TAG:   got = int'(rd_tag[p*TAG_W +: TAG_W]);
        K_COUNT: got = int'(ckpt_count);
        K_READY: got = int'(ckpt_ready);
        default: got = int'(ckpt_id);
      endcase
      check_eq(it.name, got, it.exp);
    end
  endtask

  task automatic idle();
    alloc_en = 0; alloc_wen = 0; alloc_dst = '0; alloc_tag = '0;
    ckpt_req = 0; ckpt_release = 0; recover_en = 0; recover_id = '0;
    commit_en = 0; commit_dst = '0; commit_tag = '0; flush_en = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic alloc(input int dst, input int tag);
    alloc_en = 1; alloc_wen = 1; alloc_dst = AW'(dst); alloc_tag = TAG_W'(tag);
  endtask

  task automatic commit(input int dst, input int tag);
    commit_en = 1; commit_dst = AW'(dst); commit_tag = TAG_W'(tag);
  endtask

  task automatic recover(input int id);
    recover_en = 1; recover_id = CW'(id);
  endtask

  int mh, mt, mc;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    rd_addr = '0;
    idle();
    #12;
    // Reset state, observed while reset is still held
    exp_ptr("reset", 0, 0);
    exp_map("reset.x5", 5, 0, 0);
    push("reset.x5.tag", K_TAG, 5, 0);
    drain();
    @(negedge clk);
    rst_n = 1;
    cyc();

    // Basic allocate and x0 handling
    alloc(5, 3); cyc();
    exp_map("alloc.x5", 5, 1, 3);
    exp_map("alloc.x0", 0, 0, 0);
    push("alloc.x0.tag", K_TAG, 0, 0);
    drain();
    alloc(0, 9); cyc();
    exp_map("x0write", 0, 0, 0);
    drain();

    // Commit only clears a matching tag; alloc wins over a same-cycle commit
    alloc(5, 7); commit(5, 3); cyc();
    exp_map("newer.x5", 5, 1, 7);
    drain();
    commit(5, 7); cyc();
    exp_map("retire.x5", 5, 0, 0);
    drain();
    alloc(6, 1); cyc();
    alloc(6, 2); commit(6, 1); cyc();
    exp_map("samecyc.x6", 6, 1, 2);
    drain();

    // Snapshot captures this cycle's allocate; recovery restores it
    push("pre_ckpt.id", K_ID, 0, 0);
    drain();
    alloc(1, 2); ckpt_req = 1; cyc();
    exp_ptr("ckpt0", 1, 1);
    drain();
    alloc(1, 4); cyc();
    alloc(2, 5); cyc();
    exp_map("spec.x1", 1, 1, 4);
    exp_map("spec.x2", 2, 1, 5);
    drain();
    recover(0); alloc(7, 9); cyc();
    exp_map("rec.x1", 1, 1, 2);
    exp_map("rec.x2", 2, 0, 0);
    exp_map("rec.x7dropped", 7, 0, 0);
    exp_ptr("rec", 1, 1);
    drain();
    ckpt_release = 1; cyc();
    exp_ptr("rel0", 0, 1);
    drain();

    // Commit scrubs live snapshots
    alloc(3, 6); cyc();
    ckpt_req = 1; cyc();
    commit(3, 6); cyc();
    exp_map("scrub.live.x3", 3, 0, 0);
    drain();
    recover(1); cyc();
    exp_map("scrub.rec.x3", 3, 0, 0);
    exp_ptr("scrub.rec", 1, 2);
    drain();
    ckpt_release = 1; cyc();
    exp_ptr("rel1", 0, 2);
    drain();

    // Fill all slots, overflow request, then wrap the pointers
    mh = 2; mt = 2; mc = 0;
    for (int i = 0; i < CKPT_NUM; i++) begin
      ckpt_req = 1; cyc();
      mt = (mt + 1) % CKPT_NUM; mc++;
    end
    exp_ptr("full", mc, mt);
    drain();
    ckpt_req = 1; cyc();
    exp_ptr("overflow", mc, mt);
    drain();
    ckpt_release = 1; cyc();
    mh = (mh + 1) % CKPT_NUM; mc--;
    exp_ptr("after_rel", mc, mt);
    drain();
    for (int i = 0; i < 2 * CKPT_NUM; i++) begin
      ckpt_req = 1; ckpt_release = 1; cyc();
      mh = (mh + 1) % CKPT_NUM;
      mt = (mt + 1) % CKPT_NUM;
      push($sformatf("wrap%0d.id", i), K_ID, 0, mt);
      push($sformatf("wrap%0d.count", i), K_COUNT, 0, mc);
      drain();
    end
    // Recovering to the oldest slot leaves only that slot live
    recover(mh); cyc();
    exp_ptr("rec_head", 1, (mh + 1) % CKPT_NUM);
    drain();

    // Flush overrides everything in the same cycle
    alloc(9, 1); cyc();
    exp_map("preflush.x9", 9, 1, 1);
    drain();
    flush_en = 1; alloc(10, 3); recover(mh); ckpt_req = 1; cyc();
    exp_map("flush.x9", 9, 0, 0);
    exp_map("flush.x10", 10, 0, 0);
    exp_map("flush.x1", 1, 0, 0);
    exp_ptr("flush", 0, 0);
    drain();

    // Asynchronous reset mid-operation
    alloc(11, 5); ckpt_req = 1; cyc();
    exp_map("prerst.x11", 11, 1, 5);
    exp_ptr("prerst", 1, 1);
    drain();
    @(negedge clk);
    #2;
    rst_n = 0;
    exp_map("arst.x11", 11, 0, 0);
    exp_ptr("arst", 0, 0);
    drain();
    @(negedge clk);
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
